// File: rtl/instr_cache_responder.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and a slow
// block-oriented instruction memory. Hits return in the same cycle; misses stall via BUSYWAIT.
module instr_cache_responder #(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = 3,
  parameter int ADDR_W     = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              mem_read,
  output logic [ADDR_W-5:0] mem_address,
  input  logic [127:0]      mem_readdata,
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - 4 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tag_array  [NUM_BLOCKS];
  logic [127:0]          data_array [NUM_BLOCKS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [31:0]        last_instr;

  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [127:0]       line;
  logic [31:0]        word;
  logic               hit;
  logic               fill_en;

  // Byte-lane bits and address bits above the memory size are don't-care (PC wraps).
  logic unused_pc;
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

  assign offset  = PC[3:2];
  assign index   = PC[4 +: INDEX_W];
  assign tag     = PC[4 + INDEX_W +: TAG_W];
  assign line    = data_array[index];
  assign word    = line[{offset, 5'b0} +: 32];
  assign hit     = valid[index] && (tag_array[index] == tag);
  assign fill_en = (state == FETCH) && mem_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (!hit)     state_next = FETCH;
      FETCH:   if (mem_ready) state_next = FILL;
      FILL:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // mem_read follows the registered state, so a reset during a fill drops it after the edge.
  assign mem_read    = (state == FETCH);
  assign mem_address = {req_tag, req_index};
  assign BUSYWAIT    = !RESET && ((state != IDLE) || !hit);

  always_comb begin
    INSTRUCTION = last_instr;
    if (RESET)
      INSTRUCTION = 32'h0;
    else if ((state == IDLE) && hit)
      INSTRUCTION = word;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      valid      <= '0;
      req_tag    <= '0;
      req_index  <= '0;
      last_instr <= 32'h0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (hit) begin
          last_instr <= word;
        end else begin
          req_tag   <= tag;
          req_index <= index;
        end
      end
      if (fill_en)
        valid[req_index] <= 1'b1;
    end
  end

  // NOTE: the tag/data arrays have no reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge CLK) begin
    if (!RESET && fill_en) begin
      tag_array[req_index]  <= req_tag;
      data_array[req_index] <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_instr_cache_responder.sv
// Directed bench for instr_cache_responder: cold miss, hits, conflicts, reset mid-fill,
// spurious mem_ready. Memory byte at address a holds a[7:0].
module tb_instr_cache_responder;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_ready;

  int errors = 0;
  int checks = 0;
  int req_count = 0;
  int req_base;
  logic read_q = 1'b0;

  instr_cache_responder #(.NUM_BLOCKS(8), .INDEX_W(3), .ADDR_W(10)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_ready    (mem_ready)
  );

  always #5 CLK = ~CLK;

  // Counts memory transactions as rising edges of mem_read.
  always @(negedge CLK) begin
    if (mem_read && !read_q) req_count++;
    read_q = mem_read;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] block(input logic [5:0] baddr);
    logic [127:0] b;
    logic [9:0]   a;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      a = {baddr, 4'(k)};
      b[8*k +: 8] = a[7:0];
    end
    return b;
  endfunction

  // Drives a miss from request through FETCH (lat cycles) and FILL to the re-lookup hit.
  task automatic miss_fill(input logic [31:0] pc, input int lat,
                           input logic [5:0] exp_addr, input logic [31:0] exp_word);
    PC = pc;
    #1;
    check("miss_busy", 32'(BUSYWAIT), 32'd1);
    check("miss_noread", 32'(mem_read), 32'd0);
    tick();
    check("fetch_read", 32'(mem_read), 32'd1);
    check("fetch_addr", 32'(mem_address), 32'(exp_addr));
    repeat (lat - 1) tick();
    check("fetch_hold", 32'(mem_read), 32'd1);
    check("fetch_hold_addr", 32'(mem_address), 32'(exp_addr));
    mem_readdata = block(exp_addr);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_readdata = '0;
    check("fill_busy", 32'(BUSYWAIT), 32'd1);
    check("fill_noread", 32'(mem_read), 32'd0);
    tick();
    check("hit_instr", INSTRUCTION, exp_word);
    check("hit_busy", 32'(BUSYWAIT), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    PC = 32'h0;
    mem_readdata = '0;
    mem_ready = 1'b0;
    tick();
    check("rst_busy", 32'(BUSYWAIT), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0);
    RESET = 1'b0;
    #1;
    check("cold_instr_hold", INSTRUCTION, 32'h0);

    // Cold start: memory answers 5 cycles into FETCH.
    miss_fill(32'h000, 5, 6'h00, 32'h03020100);

    // Sequential hits on consecutive cycles.
    PC = 32'h004; #1;
    check("seq4_instr", INSTRUCTION, 32'h07060504);
    check("seq4_busy", 32'(BUSYWAIT), 32'd0);
    check("seq4_read", 32'(mem_read), 32'd0);
    tick();
    PC = 32'h008; #1;
    check("seq8_instr", INSTRUCTION, 32'h0B0A0908);
    check("seq8_busy", 32'(BUSYWAIT), 32'd0);
    check("seq8_read", 32'(mem_read), 32'd0);
    tick();
    PC = 32'h00C; #1;
    check("seqC_instr", INSTRUCTION, 32'h0F0E0D0C);
    check("seqC_busy", 32'(BUSYWAIT), 32'd0);
    check("seqC_read", 32'(mem_read), 32'd0);
    tick();

    // Spurious mem_ready in IDLE while hitting: nothing may change.
    req_base = req_count;
    PC = 32'h000;
    mem_readdata = {4{32'hFFFF_FFFF}};
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_readdata = '0;
    check("spur_instr", INSTRUCTION, 32'h03020100);
    check("spur_busy", 32'(BUSYWAIT), 32'd0);
    tick();
    check("spur_instr2", INSTRUCTION, 32'h03020100);
    check("spur_read", 32'(mem_read), 32'd0);
    check("spur_reqs", 32'(req_count - req_base), 32'd0);

    // Conflict miss on index 0 with tag 1; INSTRUCTION holds meanwhile.
    PC = 32'h080; #1;
    check("conf_hold", INSTRUCTION, 32'h03020100);
    miss_fill(32'h080, 3, 6'h08, 32'h83828180);
    PC = 32'h000; #1;
    check("conf_remiss", 32'(BUSYWAIT), 32'd1);
    miss_fill(32'h000, 2, 6'h00, 32'h03020100);

    // Independent lines, exactly two transactions.
    req_base = req_count;
    miss_fill(32'h010, 2, 6'h01, 32'h13121110);
    miss_fill(32'h020, 2, 6'h02, 32'h23222120);
    PC = 32'h014; #1;
    check("ind1_instr", INSTRUCTION, 32'h17161514);
    check("ind1_busy", 32'(BUSYWAIT), 32'd0);
    PC = 32'h02C; #1;
    check("ind2_instr", INSTRUCTION, 32'h2F2E2D2C);
    check("ind2_busy", 32'(BUSYWAIT), 32'd0);
    check("ind_reqs", 32'(req_count - req_base), 32'd2);

    // PC wrap: 0x408 aliases 0x008.
    PC = 32'h0000_0408; #1;
    check("wrap_instr", INSTRUCTION, 32'h0B0A0908);
    check("wrap_busy", 32'(BUSYWAIT), 32'd0);
    tick();

    // Reset during the second FETCH cycle, then a late mem_ready.
    PC = 32'h030; #1;
    check("rf_miss", 32'(BUSYWAIT), 32'd1);
    tick();
    check("rf_fetch1", 32'(mem_read), 32'd1);
    tick();
    check("rf_fetch2", 32'(mem_read), 32'd1);
    check("rf_addr", 32'(mem_address), 32'h03);
    RESET = 1'b1;
    #1;
    check("rf_rst_busy", 32'(BUSYWAIT), 32'd0);
    tick();
    RESET = 1'b0;
    PC = 32'h000;
    mem_readdata = block(6'h03);
    mem_ready = 1'b1;
    #1;
    check("rf_read_drop", 32'(mem_read), 32'd0);
    check("rf_remiss", 32'(BUSYWAIT), 32'd1);
    check("rf_instr0", INSTRUCTION, 32'h0);
    tick();
    mem_ready = 1'b0;
    mem_readdata = '0;
    check("rf_newreq", 32'(mem_read), 32'd1);
    check("rf_newaddr", 32'(mem_address), 32'h00);
    mem_readdata = block(6'h00);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_readdata = '0;
    check("rf_fill_busy", 32'(BUSYWAIT), 32'd1);
    tick();
    check("rf_hit_instr", INSTRUCTION, 32'h03020100);
    check("rf_hit_busy", 32'(BUSYWAIT), 32'd0);
    PC = 32'h030; #1;
    check("rf_aborted_invalid", 32'(BUSYWAIT), 32'd1);
    PC = 32'h010; #1;
    check("rf_valid_cleared", 32'(BUSYWAIT), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
